// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream to instruction-memory loader
//
// Assembles big-endian 32-bit words from a byte stream and writes each one
// through a single instruction-memory write port. The core is held in reset
// until the whole image is loaded. Every word is screened against the
// opcode/funct set that the core's control unit decodes.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, len_i        start a load of len_i words (sampled in IDLE only)
//   byte_i, byte_valid_i  incoming stream byte and its valid flag
//   byte_ready_o          byte accepted this cycle when valid is also high
//   imem_we_o/addr_o/wdata_o  instruction-memory write port
//   busy_o, done_o        load in progress / one-cycle completion pulse
//   cpu_rst_o             core reset, high while the image is not valid
//   illegal_o, illegal_addr_o  sticky unsupported-word flag and first address
//   word_count_o          words written in the current load
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cpu_rst_o,
    output logic                  illegal_o,
    output logic [ADDR_WIDTH-1:0] illegal_addr_o,
    output logic [ADDR_WIDTH:0]   word_count_o
);

    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     word_count_q;
    logic [1:0]              byte_cnt_q;
    logic [23:0]             asm_q;          // first three bytes of the word
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic                    illegal_q;
    logic [ADDR_WIDTH-1:0]   illegal_addr_q;
    logic                    cpu_rst_q;

    logic [ADDR_WIDTH:0]     len_clamped;
    logic                    start_acc;
    logic                    byte_acc;
    logic                    last_word;

    // Encodings accepted by the core's control unit.
    function automatic logic word_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        if (op == 6'b000000) begin
            case (funct)
                6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100010,
                6'b100100, 6'b100101, 6'b101010, 6'b001000: ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end else begin
            case (op)
                6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000,
                6'b001010, 6'b001100, 6'b001101, 6'b100011, 6'b101011: ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    assign len_clamped = (len_i > CAPACITY) ? CAPACITY : len_i;
    assign start_acc   = (state_q == S_IDLE) && start_i;
    assign byte_acc    = (state_q == S_RECV) && byte_valid_i;
    assign last_word   = ((word_count_q + 1'b1) == len_q);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (len_clamped == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (byte_acc && (byte_cnt_q == 2'd3)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = last_word ? S_DONE : S_RECV;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        byte_ready_o = 1'b0;
        imem_we_o    = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            S_RECV: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
            end
            S_WRITE: begin
                imem_we_o = 1'b1;
                busy_o    = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath: assembly, write port registers, counters, legality tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q          <= '0;
            word_count_q   <= '0;
            byte_cnt_q     <= '0;
            asm_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            illegal_q      <= 1'b0;
            illegal_addr_q <= '0;
            cpu_rst_q      <= 1'b1;
        end else begin
            if (start_acc && (len_clamped != '0)) begin
                len_q          <= len_clamped;
                word_count_q   <= '0;
                byte_cnt_q     <= '0;
                asm_q          <= '0;
                illegal_q      <= 1'b0;
                illegal_addr_q <= '0;
                cpu_rst_q      <= 1'b1;
            end

            if (byte_acc) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                case (byte_cnt_q)
                    2'd0: asm_q[23:16] <= byte_i;
                    2'd1: asm_q[15:8]  <= byte_i;
                    2'd2: asm_q[7:0]   <= byte_i;
                    default: begin
                        // Write-port registers only change on word completion,
                        // so they hold the last written values otherwise.
                        wdata_q <= {asm_q, byte_i};
                        addr_q  <= word_count_q[ADDR_WIDTH-1:0];
                    end
                endcase
            end

            if (state_q == S_WRITE) begin
                word_count_q <= word_count_q + 1'b1;
                if (!word_legal(wdata_q[31:26], wdata_q[5:0]) && !illegal_q) begin
                    illegal_q      <= 1'b1;
                    illegal_addr_q <= addr_q;
                end
            end

            if (state_q == S_DONE) begin
                cpu_rst_q <= 1'b0;
            end
        end
    end

    assign imem_addr_o    = addr_q;
    assign imem_wdata_o   = wdata_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign illegal_o      = illegal_q;
    assign illegal_addr_o = illegal_addr_q;
    assign word_count_o   = word_count_q;

endmodule
